// File: rtl/ray_generator.sv
// ray_generator: raster-order primary ray source.
// Directions are accumulated with per-component adds from a basis latched at start.
module ray_generator #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int PIX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [95:0]      cam_origin,
  input  logic [95:0]      dir_base,
  input  logic [95:0]      step_x,
  input  logic [95:0]      step_y,
  output logic [191:0]     ray_out,
  output logic             ray_valid,
  input  logic             ray_ready,
  output logic [PIX_W-1:0] pix_x,
  output logic [PIX_W-1:0] pix_y,
  output logic             busy,
  output logic             frame_done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [95:0] org_q, org_d, sx_q, sx_d, sy_q, sy_d, row_q, row_d, cur_q, cur_d;
  logic [PIX_W-1:0] x_q, x_d, y_q, y_d;
  logic xfer, last_x, last_y, launch;

  function automatic logic [95:0] add3(input logic [95:0] a, input logic [95:0] b);
    return {a[95:64] + b[95:64], a[63:32] + b[63:32], a[31:0] + b[31:0]};
  endfunction

  assign launch = state_q == IDLE && start;
  assign xfer   = state_q == RUN && ray_ready;
  assign last_x = x_q == PIX_W'(H_RES - 1);
  assign last_y = y_q == PIX_W'(V_RES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      org_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      row_q   <= '0;
      cur_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      org_q   <= org_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      row_q   <= row_d;
      cur_q   <= cur_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = launch ? RUN :
              (xfer && last_x && last_y) ? DONE :
              state_q == DONE ? IDLE : state_q;
  end

  // row accumulator carries the start of the next row so wrapping needs no multiply
  always_comb begin
    org_d = org_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    row_d = row_q;
    cur_d = cur_q;
    x_d   = x_q;
    y_d   = y_q;
    if (launch) begin
      org_d = cam_origin;
      sx_d  = step_x;
      sy_d  = step_y;
      row_d = dir_base;
      cur_d = dir_base;
      x_d   = '0;
      y_d   = '0;
    end else if (xfer && !last_x) begin
      x_d   = x_q + 1'b1;
      cur_d = add3(cur_q, sx_q);
    end else if (xfer && !last_y) begin
      x_d   = '0;
      y_d   = y_q + 1'b1;
      row_d = add3(row_q, sy_q);
      cur_d = add3(row_q, sy_q);
    end
  end

  always_comb begin
    ray_valid  = state_q == RUN;
    busy       = state_q != IDLE;
    frame_done = state_q == DONE;
    ray_out    = {org_q, cur_q};
    pix_x      = x_q;
    pix_y      = y_q;
  end
endmodule

// File: tb/tb_ray_generator.sv
// tb_ray_generator: table vectors plus randomized backpressure against a closed-form direction model.
module tb_ray_generator;
  localparam int H = 4, V = 3, N = H * V;
  logic clk = 0, rst, start, ray_ready;
  logic [95:0] cam_origin, dir_base, step_x, step_y;
  logic [191:0] ray_out;
  logic ray_valid, busy, frame_done;
  logic [15:0] pix_x, pix_y;
  int tests = 0, fails = 0;
  logic [95:0] cap [N];

  typedef struct {int x; int y; logic [95:0] dir;} vec_t;
  vec_t tv [4];

  ray_generator #(.H_RES(H), .V_RES(V), .PIX_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cam_origin(cam_origin), .dir_base(dir_base),
    .step_x(step_x), .step_y(step_y), .ray_out(ray_out), .ray_valid(ray_valid),
    .ray_ready(ray_ready), .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // direction of pixel (x,y) straight from the definition: base + x*step_x + y*step_y, mod 2^32
  function automatic logic [95:0] model_dir(input logic [95:0] b, input logic [95:0] sx,
                                            input logic [95:0] sy, input int x, input int y);
    logic [95:0] r;
    for (int c = 0; c < 3; c++)
      r[c*32 +: 32] = b[c*32 +: 32] + 32'(x) * sx[c*32 +: 32] + 32'(y) * sy[c*32 +: 32];
    return r;
  endfunction

  task automatic run_frame(input bit rand_rdy, input int abort_at, input bit poke);
    logic [95:0] fo, fb, fsx, fsy;
    logic [223:0] prev;
    bit stalled = 0, poked = 0, rdy;
    int n = 0, cyc = 0, dones = 0;
    fo = cam_origin; fb = dir_base; fsx = step_x; fsy = step_y;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("first_valid", 224'(ray_valid), 224'(1));
    chk("first_busy", 224'(busy), 224'(1));
    while (n < N && cyc < 300) begin
      if (n == abort_at) begin
        rst = 1;
        #1;
        chk("abort_valid", 224'({ray_valid, busy, frame_done}), 224'(0));
        @(negedge clk);
        chk("abort_done", 224'(frame_done), 224'(0));
        rst = 0;
        repeat (3) begin
          @(negedge clk);
          chk("abort_idle", 224'({ray_valid, busy, frame_done}), 224'(0));
        end
        return;
      end
      if (stalled) chk("stall_hold", {ray_out, pix_x, pix_y}, prev);
      if (!ray_valid) begin
        chk("valid_drop", 224'(ray_valid), 224'(1));
        break;
      end
      if (frame_done) dones++;
      rdy = rand_rdy ? 1'($urandom % 2) : 1'b1;
      ray_ready = rdy;
      start = poke && n == 5 && !poked;
      if (start) begin poked = 1; dir_base = ~dir_base; end
      if (rdy) begin
        chk("pix", 224'({pix_x, pix_y}), 224'({16'(n % H), 16'(n / H)}));
        chk("ray", 224'(ray_out), 224'({fo, model_dir(fb, fsx, fsy, n % H, n / H)}));
        cap[n] = ray_out[95:0];
        n++;
      end
      stalled = !rdy;
      prev = {ray_out, pix_x, pix_y};
      @(negedge clk);
      start = 0;
      cyc++;
    end
    chk("transfer_count", 224'(n), 224'(N));
    chk("done_state", 224'({frame_done, busy, ray_valid}), 224'(3'b110));
    @(negedge clk);
    chk("after_done", 224'({frame_done, busy, ray_valid}), 224'(0));
    repeat (5) begin
      @(negedge clk);
      if (frame_done || ray_valid) dones++;
    end
    chk("no_extra_done", 224'(dones), 224'(0));
  endtask

  task automatic set_plan;
    cam_origin = {32'h0, 32'h0, 32'hf0000000};
    dir_base   = {32'hf0000000, 32'h08000000, 32'h10000000};
    step_x     = {32'h02000000, 32'h0, 32'h0};
    step_y     = {32'h0, 32'hfe000000, 32'h0};
  endtask

  initial begin
    tv[0] = '{0, 0, {32'hf0000000, 32'h08000000, 32'h10000000}};
    tv[1] = '{1, 0, {32'hf2000000, 32'h08000000, 32'h10000000}};
    tv[2] = '{0, 1, {32'hf0000000, 32'h06000000, 32'h10000000}};
    tv[3] = '{3, 2, {32'hf6000000, 32'h04000000, 32'h10000000}};
    rst = 1; start = 0; ray_ready = 0;
    set_plan();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_flags", 224'({ray_valid, busy, frame_done}), 224'(0));
      chk("idle_ray", 224'(ray_out), 224'(0));
    end
    run_frame(0, -1, 0);
    foreach (tv[i]) chk($sformatf("table_%0d_%0d", tv[i].x, tv[i].y), 224'(cap[tv[i].y * H + tv[i].x]), 224'(tv[i].dir));
    set_plan();
    run_frame(1, -1, 0);
    foreach (tv[i]) chk("table_bp", 224'(cap[tv[i].y * H + tv[i].x]), 224'(tv[i].dir));
    set_plan();
    run_frame(1, -1, 1);
    chk("poke_last", 224'(cap[N-1]), 224'(tv[3].dir));
    set_plan();
    dir_base[95:64] = 32'h7fffffff;
    step_x[95:64] = 32'h00000001;
    run_frame(0, -1, 0);
    chk("wrap_x", 224'(cap[1][95:64]), 224'(32'h80000000));
    set_plan();
    run_frame(0, 6, 0);
    run_frame(0, -1, 0);
    chk("restart_base", 224'(cap[0]), 224'(tv[0].dir));
    repeat (3) begin
      cam_origin = {$urandom, $urandom, $urandom};
      dir_base   = {$urandom, $urandom, $urandom};
      step_x     = {$urandom, $urandom, $urandom};
      step_y     = {$urandom, $urandom, $urandom};
      run_frame(1, -1, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
